// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
// Holds the fetch/execute state enum and PC constants.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        ERROR = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: PC+4, branch or jump (jump wins).
// Ports: pc, jump, pc_src, inm26, sign_xtended -> next_pc.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic        pc_src,
    input  logic [25:0] inm26,
    input  logic [31:0] sign_xtended,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;

    // Word offset becomes a byte offset; the top two bits drop out.
    logic [1:0]  unused_sx;
    assign unused_sx = sign_xtended[31:30];

    assign pc4       = pc + PC_INC;
    assign br_target = pc4 + {sign_xtended[29:0], 2'b00};
    assign j_target  = {pc4[31:28], inm26, 2'b00};

    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = j_target;
        end else if (pc_src) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// MIPS front end: PC register, fetch handshake, execute slot, retire count.
// Ports: clk/reset, imem_req/addr/ack/data, instr/instr_valid,
// stall/halt/jump/pc_src/inm26/sign_xtended, pc, retired, halted, fetch_err.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        halt,
    input  logic        jump,
    input  logic        pc_src,
    input  logic [25:0] inm26,
    input  logic [31:0] sign_xtended,
    output logic [31:0] pc,
    output logic [31:0] retired,
    output logic        halted,
    output logic        fetch_err
);

    localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(FETCH_TIMEOUT - 1);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ret_q, ret_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] next_pc;

    next_pc_calc u_next_pc (
        .pc           (pc_q),
        .jump         (jump),
        .pc_src       (pc_src),
        .inm26        (inm26),
        .sign_xtended (sign_xtended),
        .next_pc      (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ret_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    cnt_d   = '0;
                    state_d = EXEC;
                end else if (cnt_q == TO_LAST) begin
                    // Last allowed wait cycle without an ack.
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                if (halt) begin
                    ret_d   = ret_q + 32'd1;
                    state_d = HALT;
                end else if (!stall) begin
                    pc_d    = next_pc;
                    ret_d   = ret_q + 32'd1;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            ERROR: begin
                state_d = ERROR;
            end
        endcase
    end

    // Outputs depend on registered state only.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALT) || (state_q == ERROR);
    assign fetch_err   = (state_q == ERROR);
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign retired     = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a behavioural model.
// Directed test-plan steps followed by a randomized run.
module tb_pc_sequencer;

    localparam int unsigned TB_FT = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_ack = 1'b0;
    logic        ack2 = 1'b0;
    logic [31:0] imem_data = '0;
    logic        stall = 1'b0;
    logic        halt = 1'b0;
    logic        jump = 1'b0;
    logic        pc_src = 1'b0;
    logic [25:0] inm26 = '0;
    logic [31:0] sx = '0;

    logic        imem_req, instr_valid, halted, fetch_err;
    logic [31:0] imem_addr, instr, pc, retired;

    logic        req2, iv2, halted2, err2;
    logic [31:0] addr2, instr2, pc2, ret2;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC      (32'h0),
        .FETCH_TIMEOUT (TB_FT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .halt         (halt),
        .jump         (jump),
        .pc_src       (pc_src),
        .inm26        (inm26),
        .sign_xtended (sx),
        .pc           (pc),
        .retired      (retired),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    pc_sequencer #(
        .RESET_PC      (WRAP_PC),
        .FETCH_TIMEOUT (16)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (req2),
        .imem_addr    (addr2),
        .imem_ack     (ack2),
        .imem_data    (imem_data),
        .instr        (instr2),
        .instr_valid  (iv2),
        .stall        (stall),
        .halt         (halt),
        .jump         (jump),
        .pc_src       (pc_src),
        .inm26        (inm26),
        .sign_xtended (sx),
        .pc           (pc2),
        .retired      (ret2),
        .halted       (halted2),
        .fetch_err    (err2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0 waiting for fetch, 1 executing, 2 halted, 3 failed.
    bit          m_known = 0;
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ret;
    int          m_wait;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] p);
        logic [31:0] seq;
        seq = p + 32'd4;
        if (jump)
            return (seq & 32'hF000_0000) | ({6'd0, inm26} << 2);
        if (pc_src)
            return seq + (sx << 2);
        return seq;
    endfunction

    task automatic step();
        if (m_known) begin
            chk("imem_req",    {31'd0, imem_req},    {31'd0, m_mode == 0});
            chk("imem_addr",   imem_addr,            m_pc);
            chk("pc",          pc,                   m_pc);
            chk("instr",       instr,                m_instr);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_mode == 1});
            chk("retired",     retired,              m_ret);
            chk("halted",      {31'd0, halted},      {31'd0, m_mode >= 2});
            chk("fetch_err",   {31'd0, fetch_err},   {31'd0, m_mode == 3});
        end
        if (reset) begin
            m_known = 1;
            m_mode  = 0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_ret   = 32'h0;
            m_wait  = 0;
        end else if (m_known) begin
            if (m_mode == 0) begin
                if (imem_ack) begin
                    m_instr = imem_data;
                    m_wait  = 0;
                    m_mode  = 1;
                end else begin
                    m_wait++;
                    if (m_wait == TB_FT) m_mode = 3;
                end
            end else if (m_mode == 1) begin
                if (halt) begin
                    m_ret  = m_ret + 1;
                    m_mode = 2;
                end else if (!stall) begin
                    m_pc   = ref_next(m_pc);
                    m_ret  = m_ret + 1;
                    m_mode = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // One instruction: ack in first fetch cycle, then one exec cycle.
    task automatic one_instr(input logic j, input logic b,
                             input logic [25:0] imm,
                             input logic [31:0] off);
        imem_ack  = 1'b1;
        imem_data = $urandom;
        step();
        imem_ack = 1'b0;
        jump     = j;
        pc_src   = b;
        inm26    = imm;
        sx       = off;
        step();
        jump   = 1'b0;
        pc_src = 1'b0;
    endtask

    logic [31:0] save_pc, save_ret, save_instr;

    initial begin
        do_reset();
        chk("rst_pc",  pc,                32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);

        // Sequential run
        repeat (3) one_instr(1'b0, 1'b0, 26'd0, 32'd0);
        chk("seq_pc",  pc,      32'h0000_000C);
        chk("seq_ret", retired, 32'd3);

        // Branch back, far branch, then jump beating branch
        one_instr(1'b0, 1'b0, 26'd0, 32'd0);
        chk("pre_br_pc", pc, 32'h0000_0010);
        one_instr(1'b0, 1'b1, 26'd0, 32'hFFFF_FFFE);
        chk("br_back_pc", pc, 32'h0000_000C);
        one_instr(1'b0, 1'b1, 26'd0, 32'h0FFF_FFFC);
        chk("br_far_pc", pc, 32'h4000_0000);
        one_instr(1'b1, 1'b1, 26'h3FF_FFFF, 32'h0000_0100);
        chk("jump_pc", pc, 32'h4FFF_FFFC);

        // Stall three cycles, then halt with stall
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        save_pc    = pc;
        save_ret   = retired;
        save_instr = instr;
        stall      = 1'b1;
        jump       = 1'b1;
        repeat (3) step();
        chk("stall_pc",    pc,                   save_pc);
        chk("stall_ret",   retired,              save_ret);
        chk("stall_instr", instr,                save_instr);
        chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        halt = 1'b1;
        step();
        halt  = 1'b0;
        stall = 1'b0;
        jump  = 1'b0;
        chk("halt_halted", {31'd0, halted},   32'd1);
        chk("halt_ret",    retired,           save_ret + 32'd1);
        chk("halt_pc",     pc,                save_pc);
        imem_ack = 1'b1;
        repeat (3) step();
        imem_ack = 1'b0;
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_err", {31'd0, fetch_err}, 32'd0);

        // Fetch timeout
        do_reset();
        repeat (TB_FT) step();
        chk("to_err",    {31'd0, fetch_err}, 32'd1);
        chk("to_halted", {31'd0, halted},    32'd1);
        imem_ack = 1'b1;
        repeat (2) step();
        imem_ack = 1'b0;
        chk("to_late_ack", {31'd0, fetch_err}, 32'd1);
        chk("to_req",      {31'd0, imem_req},  32'd0);

        // Reset in the second fetch cycle
        do_reset();
        one_instr(1'b0, 1'b0, 26'd0, 32'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_pc",  pc,                32'h0);
        chk("mid_ret", retired,           32'd0);
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        repeat (TB_FT - 1) step();
        chk("mid_no_err", {31'd0, fetch_err}, 32'd0);
        step();
        chk("mid_err", {31'd0, fetch_err}, 32'd1);

        // Wrap-around on the second instance
        do_reset();
        chk("wrap_rst_pc", pc2, WRAP_PC);
        ack2 = 1'b1;
        step();
        ack2 = 1'b0;
        chk("wrap_valid", {31'd0, iv2}, 32'd1);
        step();
        chk("wrap_pc",  pc2,  32'h0);
        chk("wrap_ret", ret2, 32'd1);
        chk("wrap_req", {31'd0, req2}, 32'd1);

        // Randomized run
        do_reset();
        for (int i = 0; i < 600; i++) begin
            imem_ack  = ($urandom_range(0, 9) < 7);
            imem_data = $urandom;
            stall     = ($urandom_range(0, 9) < 3);
            halt      = ($urandom_range(0, 49) == 0);
            jump      = ($urandom_range(0, 4) == 0);
            pc_src    = ($urandom_range(0, 9) < 3);
            inm26     = 26'($urandom);
            sx        = $urandom;
            reset     = ($urandom_range(0, 99) < 2) ||
                        (m_mode >= 2 && $urandom_range(0, 4) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
